// File: rtl/rtu_pst_pkg.sv
//------------------------------------------------------------------------------
// rtu_pst_pkg : shared PST constants, entry state encoding and popcount helper
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rtu_pst_pkg;

    localparam int PREG_NUM = 64;
    localparam int PREG_W   = 6;
    localparam int GPR_NUM  = 32;
    localparam int QDEPTH   = 2;

    typedef enum logic [4:0] {
        PST_DEALLOC  = 5'b00001,
        PST_WF_ALLOC = 5'b00010,
        PST_ALLOC    = 5'b00100,
        PST_RETIRE   = 5'b01000,
        PST_RELEASE  = 5'b10000
    } pst_state_e;

    function automatic logic [6:0] popcount_preg(input logic [PREG_NUM-1:0] vec);
        logic [6:0] sum;
        sum = '0;
        for (int i = 0; i < PREG_NUM; i++) begin
            sum = sum + 7'(vec[i]);
        end
        return sum;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rtu_pst_prio_enc.sv
//------------------------------------------------------------------------------
// rtu_pst_prio_enc : lowest-set-bit priority encoder (index, one-hot, any)
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rtu_pst_prio_enc #(
    parameter int N = 64,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         any
);

    // Descending scan so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

    assign onehot = req & (~req + N'(1));
    assign any    = |req;

endmodule

`default_nettype wire

// File: rtl/rtu_pst_preg_alloc.sv
//------------------------------------------------------------------------------
// rtu_pst_preg_alloc : picks free pregs into a 2-deep pre-alloc FIFO and hands
//                      them to IDU rename, strobing the PST entries on each move
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rtu_pst_preg_alloc
    import rtu_pst_pkg::*;
(
    input  logic                clk,
    input  logic                rst_clk,
    input  logic                rtu_global_flush,
    input  logic [PREG_NUM-1:0] pst_preg_dealloc_vec,
    input  logic                idu_rtu_preg_req,
    output logic [PREG_NUM-1:0] pst_pre_alloc_vld_vec,
    output logic [PREG_NUM-1:0] pst_alloc_vld_vec,
    output logic                rtu_idu_preg_vld,
    output logic [PREG_W-1:0]   rtu_idu_preg_index,
    output logic [6:0]          rtu_idu_preg_free_cnt
);

    logic [PREG_W-1:0]   slot [QDEPTH];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          cnt;

    logic [PREG_W-1:0]   sel_idx;
    logic [PREG_NUM-1:0] sel_onehot;
    logic                sel_any;

    logic                pop;
    logic                push;
    logic [1:0]          cnt_after_pop;

    rtu_pst_prio_enc #(
        .N (PREG_NUM),
        .W (PREG_W)
    ) u_prio_enc (
        .req    (pst_preg_dealloc_vec),
        .idx    (sel_idx),
        .onehot (sel_onehot),
        .any    (sel_any)
    );

    assign rtu_idu_preg_vld   = (cnt != 2'd0);
    assign rtu_idu_preg_index = slot[rd_ptr];

    assign pop           = idu_rtu_preg_req & rtu_idu_preg_vld & ~rtu_global_flush;
    assign cnt_after_pop = cnt - {1'b0, pop};
    assign push          = sel_any & ~rtu_global_flush & (cnt_after_pop < 2'(QDEPTH));

    // Strobes are combinational, so hold them low while reset is asserted.
    assign pst_alloc_vld_vec     = (pop & rst_clk)  ? (PREG_NUM'(1) << rtu_idu_preg_index) : '0;
    assign pst_pre_alloc_vld_vec = (push & rst_clk) ? sel_onehot : '0;

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            cnt     <= 2'd0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            slot[0] <= '0;
            slot[1] <= '0;
        end else if (rtu_global_flush) begin
            cnt    <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push) begin
                slot[wr_ptr] <= sel_idx;
                wr_ptr       <= ~wr_ptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            rtu_idu_preg_free_cnt <= 7'd0;
        end else begin
            rtu_idu_preg_free_cnt <= popcount_preg(pst_preg_dealloc_vec);
        end
    end

endmodule

`default_nettype wire
